queue_people_counter: RTL



---
 rtl/queue_people_counter_pkg.sv | 18 +
 rtl/queue_people_counter_debounce.sv | 111 +++++++++++
 rtl/queue_people_counter.sv | 109 ++++++++++
 3 files changed

// File: rtl/queue_people_counter_pkg.sv
// Shared constants and debounce state encoding for the bank-queue people counter.
package queue_pkg;

  localparam int MAX_COUNT  = 7;
  localparam int CNT_W      = 4;
  localparam int DEB_CYCLES = 4;
  localparam int DEB_W      = 3;

  localparam logic [CNT_W-1:0] MAX_PCOUNT   = CNT_W'(MAX_COUNT);
  localparam logic [1:0]       TELLER_RESET = 2'b01;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    HELD  = 2'd2
  } deb_state_t;

endpackage

// File: rtl/queue_people_counter_debounce.sv
// Two-flop synchronizer plus debounce FSM; emits one single-cycle event per
// qualified beam interruption.
module sensor_debounce
  import queue_pkg::*;
#(
  parameter int DEB_N = DEB_CYCLES,
  parameter int DW    = DEB_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_sensor,
  output logic o_event
);

  logic          r_sync1;
  logic          r_sync2;
  logic [1:0]    r_fill;
  logic          r_post_rst;
  deb_state_t    r_state;
  deb_state_t    w_state_nxt;
  logic [DW-1:0] r_cnt;
  logic [DW-1:0] w_cnt_nxt;
  logic [DW-1:0] w_cnt_inc;
  logic          w_hit;
  logic          r_event;
  logic          w_event_nxt;

  assign w_cnt_inc = r_cnt + DW'(1);
  assign w_hit     = (w_cnt_inc == DW'(DEB_N));

  // r_fill marks when r_sync2 holds a real sample again after reset; until a
  // valid low sample is seen, a beam already blocked is parked in HELD.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_fill     <= 2'b00;
      r_post_rst <= 1'b1;
    end else begin
      r_sync1 <= i_sensor;
      r_sync2 <= r_sync1;
      r_fill  <= {r_fill[0], 1'b1};
      if (r_fill[1] && !r_sync2) r_post_rst <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_event <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_event <= w_event_nxt;
    end
  end

  // NOTE: every combinational output gets a default first so no path through
  // the case leaves it unassigned, which would infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (r_sync2) begin
          if (r_post_rst || DEB_N == 1) begin
            w_state_nxt = HELD;
          end else begin
            w_state_nxt = ARMED;
            w_cnt_nxt   = DW'(1);
          end
        end
      end
      ARMED: begin
        if (!r_sync2) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
          if (w_hit) w_state_nxt = HELD;
        end
      end
      HELD: begin
        if (!r_sync2) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    w_event_nxt = 1'b0;
    case (r_state)
      IDLE:    w_event_nxt = r_sync2 && !r_post_rst && (DEB_N == 1);
      ARMED:   w_event_nxt = r_sync2 && w_hit;
      default: w_event_nxt = 1'b0;
    endcase
  end

  assign o_event = r_event;

endmodule

// File: rtl/queue_people_counter.sv
// Saturating people counter, status flags and teller-count register feeding
// the waiting-time ROM.
module queue_people_counter
  import queue_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             entry_sensor,
  input  logic             exit_sensor,
  input  logic [1:0]       teller_sel,
  output logic [CNT_W-1:0] pcount,
  output logic [1:0]       tcount,
  output logic             full,
  output logic             empty,
  output logic             ovf,
  output logic             unf,
  output logic             upd
);

  logic             w_entry_evt;
  logic             w_exit_evt;
  logic [CNT_W-1:0] r_pcount;
  logic [CNT_W-1:0] w_pcount_nxt;
  logic [1:0]       r_tcount;
  logic             r_full;
  logic             r_empty;
  logic             r_ovf;
  logic             r_unf;
  logic             r_upd;
  logic             w_ovf;
  logic             w_unf;
  logic             w_upd;

  sensor_debounce u_entry_deb (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_sensor (entry_sensor),
    .o_event  (w_entry_evt)
  );

  sensor_debounce u_exit_deb (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_sensor (exit_sensor),
    .o_event  (w_exit_evt)
  );

  // Simultaneous entry and exit cancel out: no change and no alarm pulse.
  always_comb begin
    w_pcount_nxt = r_pcount;
    w_ovf        = 1'b0;
    w_unf        = 1'b0;
    w_upd        = 1'b0;
    case ({w_entry_evt, w_exit_evt})
      2'b10: begin
        if (r_full) begin
          w_ovf = 1'b1;
        end else begin
          w_pcount_nxt = r_pcount + CNT_W'(1);
          w_upd        = 1'b1;
        end
      end
      2'b01: begin
        if (r_empty) begin
          w_unf = 1'b1;
        end else begin
          w_pcount_nxt = r_pcount - CNT_W'(1);
          w_upd        = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pcount <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
      r_upd    <= 1'b0;
    end else begin
      r_pcount <= w_pcount_nxt;
      r_full   <= (w_pcount_nxt == MAX_PCOUNT);
      r_empty  <= (w_pcount_nxt == '0);
      r_ovf    <= w_ovf;
      r_unf    <= w_unf;
      r_upd    <= w_upd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tcount <= TELLER_RESET;
    end else if (teller_sel != 2'd0) begin
      r_tcount <= teller_sel;
    end
  end

  assign pcount = r_pcount;
  assign tcount = r_tcount;
  assign full   = r_full;
  assign empty  = r_empty;
  assign ovf    = r_ovf;
  assign unf    = r_unf;
  assign upd    = r_upd;

endmodule
